// File: rtl/alu_pkg.sv
// alu_pkg: op codes, flag bit positions and FSM states shared by the multi-cycle ALU
package alu_pkg;
   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_NOR = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;
   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_SRA = 4'b1001;
   localparam logic [3:0] OP_SRL = 4'b1010;
   localparam logic [3:0] OP_MUL = 4'b1100;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;
   typedef enum logic {ST_IDLE, ST_MUL} state_e;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one multiplier bit per cycle, LSB first
//  start_i : capture a_i/b_i and begin (ignored while busy)
//  done_o  : high in the cycle whose edge retires the last bit; prod_o is valid then
//  prod_o  : low WIDTH bits of the unsigned product (accumulator next value)
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] prod_o
);
   localparam int CW = $clog2(WIDTH);
   logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   assign acc_d  = acc_q + (b_q[0] ? a_q : '0);
   assign done_o = busy_q & (cnt_q == CW'(WIDTH - 1));
   assign prod_o = acc_d;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start_i && !busy_q) begin
         a_q    <= a_i;
         b_q    <= b_i;
         acc_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         acc_q  <= acc_d;
         a_q    <= a_q << 1;
         b_q    <= b_q >> 1;
         cnt_q  <= cnt_q + CW'(1);
         busy_q <= ~done_o;
      end
   end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes, {N,Z,C,V} flags and iterative MUL
//  in_valid/in_ready/dataa/datab/Function : operand side, accept = in_valid & in_ready
//  out_valid/out_ready/result/flags/illegal : registered result side, pop = out_valid & out_ready
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dataa,
   input  logic [WIDTH-1:0] datab,
   input  logic [3:0]       Function,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             illegal
);
   localparam int SHW = $clog2(WIDTH);
   state_e           state_q, state_d;
   logic             ov_q, ill_q, ill_d, c_d, v_d;
   logic [WIDTH-1:0] res_q, res_d, mul_prod;
   logic [3:0]       flg_q, flg_d;
   logic             accept, mul_start, mul_done, load;
   logic [SHW-1:0]   sh;
   logic [WIDTH:0]   sum, diff, sll_x, srl_x, sra_x;
   assign in_ready  = (state_q == ST_IDLE) & (~ov_q | out_ready);
   assign accept    = in_valid & in_ready;
   assign mul_start = accept & (Function == OP_MUL);
   assign load      = (accept & ~mul_start) | mul_done;
   assign sh        = datab[SHW-1:0];
   assign sum       = {1'b0, dataa} + {1'b0, datab};
   assign diff      = {1'b0, dataa} - {1'b0, datab};
   // Shifts run one bit wider so the extra bit catches the last bit shifted out (0 for amount 0).
   assign sll_x     = {1'b0, dataa} << sh;
   assign srl_x     = {dataa, 1'b0} >> sh;
   assign sra_x     = $signed({dataa, 1'b0}) >>> sh;
   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (mul_start),
      .a_i     (dataa),
      .b_i     (datab),
      .done_o  (mul_done),
      .prod_o  (mul_prod)
   );
   always_comb begin
      state_d = mul_start ? ST_MUL : (mul_done ? ST_IDLE : state_q);
   end
   always_comb begin
      res_d = '0;
      c_d   = 1'b0;
      v_d   = 1'b0;
      ill_d = 1'b0;
      case (Function)
         OP_ADD: begin
            res_d = sum[WIDTH-1:0];
            c_d   = sum[WIDTH];
            v_d   = (dataa[WIDTH-1] == datab[WIDTH-1]) & (sum[WIDTH-1] != dataa[WIDTH-1]);
         end
         OP_SUB: begin
            res_d = diff[WIDTH-1:0];
            c_d   = diff[WIDTH];
            v_d   = (dataa[WIDTH-1] != datab[WIDTH-1]) & (diff[WIDTH-1] != dataa[WIDTH-1]);
         end
         OP_AND: res_d = dataa & datab;
         OP_OR:  res_d = dataa | datab;
         OP_NOR: res_d = ~(dataa | datab);
         OP_XOR: res_d = dataa ^ datab;
         OP_SLL: begin
            res_d = sll_x[WIDTH-1:0];
            c_d   = sll_x[WIDTH];
         end
         OP_SRA: begin
            res_d = sra_x[WIDTH:1];
            c_d   = sra_x[0];
         end
         OP_SRL: begin
            res_d = srl_x[WIDTH:1];
            c_d   = srl_x[0];
         end
         OP_MUL: res_d = '0;
         default: ill_d = 1'b1;
      endcase
      // While multiplying, the only thing that can load the output is the product.
      if (state_q == ST_MUL) begin
         res_d = mul_prod;
         c_d   = 1'b0;
         v_d   = 1'b0;
         ill_d = 1'b0;
      end
      flg_d         = '0;
      flg_d[FLAG_N] = ~ill_d & res_d[WIDTH-1];
      flg_d[FLAG_Z] = ~ill_d & (res_d == '0);
      flg_d[FLAG_C] = ~ill_d & c_d;
      flg_d[FLAG_V] = ~ill_d & v_d;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ov_q    <= 1'b0;
         res_q   <= '0;
         flg_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            ov_q  <= 1'b1;
            res_q <= res_d;
            flg_q <= flg_d;
            ill_q <= ill_d;
         end else if (ov_q && out_ready) begin
            ov_q <= 1'b0;
         end
      end
   end
   assign out_valid = ov_q;
   assign result    = res_q;
   assign flags     = flg_q;
   assign illegal   = ill_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at WIDTH=32
module tb_alu_mc;
   import alu_pkg::*;
   typedef struct packed {
      logic [3:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [3:0]  fl;
      logic        il;
   } vec_t;
   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [31:0] dataa = '0, datab = '0;
   logic [3:0]  Function = '0;
   logic        in_ready, out_valid, illegal;
   logic [31:0] result;
   logic [3:0]  flags;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   alu_mc #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dataa     (dataa),
      .datab     (datab),
      .Function  (Function),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .illegal   (illegal)
   );
   task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      Function = f;
      dataa    = a;
      datab    = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask
   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      Function = OP_ADD;
      dataa    = 32'd1;
      datab    = 32'd1;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || result !== 32'h0 || flags !== 4'h0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got v=%b r=%h f=%b i=%b want v=0 r=0 f=0 i=0", out_valid, result, flags, illegal);
      end
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got in_ready=%b v=%b want in_ready=1 v=0", in_ready, out_valid);
      end
   endtask
   task automatic test_arith();
      vec_t v[9];
      v = '{
         {OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1'b0},
         {OP_SUB, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'b1010, 1'b0},
         {OP_SUB, 32'h00000003, 32'h00000003, 32'h00000000, 4'b0100, 1'b0},
         {OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 1'b0},
         {OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001, 1'b0},
         {OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 1'b0},
         {OP_OR,  32'h0000F0F0, 32'h00000F00, 32'h0000FFF0, 4'b0000, 1'b0},
         {OP_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b1000, 1'b0},
         {OP_XOR, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 4'b0100, 1'b0}
      };
      foreach (v[i]) begin
         issue(v[i].f, v[i].a, v[i].b);
         checks++;
         if (out_valid !== 1'b1 || result !== v[i].r || flags !== v[i].fl || illegal !== v[i].il) begin
            errors++;
            $display("FAIL arith[%0d] got v=%b r=%h f=%b i=%b want v=1 r=%h f=%b i=%b",
                     i, out_valid, result, flags, illegal, v[i].r, v[i].fl, v[i].il);
         end
      end
   endtask
   task automatic test_shift_illegal();
      vec_t v[10];
      v = '{
         {OP_SRA, 32'h80000000, 32'd4,  32'hF8000000, 4'b1000, 1'b0},
         {OP_SRL, 32'h80000001, 32'd1,  32'h40000000, 4'b0010, 1'b0},
         {OP_SLL, 32'h12345678, 32'd0,  32'h12345678, 4'b0000, 1'b0},
         {OP_SLL, 32'h80000001, 32'd1,  32'h00000002, 4'b0010, 1'b0},
         {OP_SRL, 32'h80000000, 32'd31, 32'h00000001, 4'b0000, 1'b0},
         {OP_SRA, 32'h000000F0, 32'h24, 32'h0000000F, 4'b0000, 1'b0},
         {OP_SLL, 32'h00000003, 32'd31, 32'h80000000, 4'b1010, 1'b0},
         {4'b1111, 32'h00000005, 32'd3, 32'h00000000, 4'b0000, 1'b1},
         {4'b0001, 32'h7FFFFFFF, 32'd1, 32'h00000000, 4'b0000, 1'b1},
         {OP_ADD, 32'h00000001, 32'd1,  32'h00000002, 4'b0000, 1'b0}
      };
      foreach (v[i]) begin
         issue(v[i].f, v[i].a, v[i].b);
         checks++;
         if (out_valid !== 1'b1 || result !== v[i].r || flags !== v[i].fl || illegal !== v[i].il) begin
            errors++;
            $display("FAIL shift[%0d] got v=%b r=%h f=%b i=%b want v=1 r=%h f=%b i=%b",
                     i, out_valid, result, flags, illegal, v[i].r, v[i].fl, v[i].il);
         end
      end
   endtask
   task automatic test_mul();
      vec_t v[4];
      v = '{
         {OP_MUL, 32'h00010003, 32'h00000005, 32'h0005000F, 4'b0000, 1'b0},
         {OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 1'b0},
         {OP_MUL, 32'h80000000, 32'h00000003, 32'h80000000, 4'b1000, 1'b0},
         {OP_MUL, 32'h00000000, 32'h12345678, 32'h00000000, 4'b0100, 1'b0}
      };
      foreach (v[i]) begin
         issue(v[i].f, v[i].a, v[i].b);
         dataa    = 32'hDEADBEEF;
         datab    = 32'hCAFEF00D;
         Function = 4'hF;
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mul_start[%0d] got in_ready=%b v=%b want 0 0", i, in_ready, out_valid);
         end
         for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'(c == 32)) begin
               errors++;
               $display("FAIL mul_latency[%0d] cycle %0d got v=%b want %b", i, c, out_valid, c == 32);
            end
            if (c < 32) begin
               checks++;
               if (in_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL mul_busy[%0d] cycle %0d got in_ready=%b want 0", i, c, in_ready);
               end
            end
         end
         checks++;
         if (result !== v[i].r || flags !== v[i].fl || illegal !== 1'b0) begin
            errors++;
            $display("FAIL mul_result[%0d] got r=%h f=%b i=%b want r=%h f=%b i=0",
                     i, result, flags, illegal, v[i].r, v[i].fl);
         end
      end
   endtask
   task automatic test_back_to_back();
      @(negedge clk);
      out_ready = 1'b0;
      Function  = OP_ADD;
      dataa     = 32'd10;
      datab     = 32'd1;
      in_valid  = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd11 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_first got v=%b r=%0d in_ready=%b want v=1 r=11 in_ready=0", out_valid, result, in_ready);
      end
      dataa = 32'd20;
      datab = 32'd2;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || result !== 32'd11 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold got v=%b r=%0d in_ready=%b want v=1 r=11 in_ready=0", out_valid, result, in_ready);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_ready_comb got in_ready=%b want 1", in_ready);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd22) begin
         errors++;
         $display("FAIL bp_second got v=%b r=%0d want v=1 r=22", out_valid, result);
      end
      dataa = 32'd30;
      datab = 32'd3;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd33) begin
         errors++;
         $display("FAIL bp_third got v=%b r=%0d want v=1 r=33", out_valid, result);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain got v=%b want 0", out_valid);
      end
   endtask
   task automatic test_reset_mid_mul();
      int seen;
      issue(OP_MUL, 32'h00012345, 32'h00006789);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midmul_reset got v=%b in_ready=%b want v=0 in_ready=1", out_valid, in_ready);
      end
      rst_n = 1'b1;
      seen  = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL midmul_discard got %0d valid cycles want 0", seen);
      end
      issue(OP_ADD, 32'd1, 32'd1);
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd2 || flags !== 4'b0000) begin
         errors++;
         $display("FAIL midmul_next_add got v=%b r=%0d f=%b want v=1 r=2 f=0000", out_valid, result, flags);
      end
   endtask
   initial begin
      test_reset();
      test_arith();
      test_shift_illegal();
      test_mul();
      test_back_to_back();
      test_reset_mid_mul();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL timeout got no completion want finish before 1ms");
      $fatal(1, "timeout");
   end
endmodule
